// File: rtl/data_mem_ctrl_if.sv
// Word-addressed data bus between the load/store controller and the memory fabric.
// The controller owns the request side; the fabric returns grant, read-valid and data.
interface data_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store responder: steers byte lanes, extends load data, stalls the pipeline
// while the bus access is outstanding, and aborts accesses the fabric never answers.
module data_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       memRW,
    input  logic [2:0]       func3,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             stall,
    output logic             done,
    output logic             acc_fault,
    output logic             bus_err,
    data_mem_ctrl_if.master  bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     addr_q;
    logic [1:0]      lane_q;
    logic [2:0]      func3_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;

    logic            valid, is_write, illegal, misaligned, fault;
    logic [3:0]      be_n;
    logic [31:0]     wdata_n;
    logic            timer_hit, abort, entering;
    logic [31:0]     shifted;
    logic [7:0]      load_b;
    logic [15:0]     load_h;
    logic [31:0]     load_val;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        valid      = (memRW == 2'b01) || (memRW == 2'b10);
        is_write   = (memRW == 2'b10);
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (func3)
            3'b000: ;
            3'b001: misaligned = addr[0];
            3'b010: misaligned = |addr[1:0];
            3'b100: illegal = is_write;
            3'b101: begin
                illegal    = is_write;
                misaligned = addr[0];
            end
            default: illegal = 1'b1;
        endcase
        fault = illegal | misaligned;

        be_n    = 4'b1111;
        wdata_n = wdata;
        case (func3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << addr[1:0];
                wdata_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_n    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign timer_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = valid & ~fault;
                if (valid && !fault) state_d = REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (bus.gnt) begin
                    state_d = we_q ? DONE : RESP;
                end else if (timer_hit) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            RESP: begin
                stall = 1'b1;
                if (bus.rvalid) begin
                    state_d = DONE;
                end else if (timer_hit) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction works on the latched low address bits, not the live ALU address.
    always_comb begin
        shifted = bus.rdata >> {lane_q, 3'b000};
        load_b  = shifted[7:0];
        load_h  = lane_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (func3_q)
            3'b000:  load_val = {{24{load_b[7]}}, load_b};
            3'b001:  load_val = {{16{load_h[15]}}, load_h};
            3'b100:  load_val = {24'd0, load_b};
            3'b101:  load_val = {16'd0, load_h};
            default: load_val = bus.rdata;
        endcase
    end

    assign entering = ((state_d == REQ) && (state_q != REQ)) ||
                      ((state_d == RESP) && (state_q != RESP));

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            lane_q    <= '0;
            func3_q   <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            acc_fault <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_fault <= (state_q == IDLE) && valid && fault;
            bus_err   <= abort;

            if (entering) begin
                cnt_q <= '0;
            end else if ((state_q == REQ) || (state_q == RESP)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if ((state_q == IDLE) && valid && !fault) begin
                addr_q  <= {addr[31:2], 2'b00};
                lane_q  <= addr[1:0];
                func3_q <= func3;
                we_q    <= is_write;
                be_q    <= be_n;
                wdata_q <= wdata_n;
            end

            if (abort) begin
                rdata <= '0;
            end else if ((state_q == RESP) && bus.rvalid) begin
                rdata <= load_val;
            end
        end
    end

    assign done      = (state_q == DONE);
    assign bus.req   = (state_q == REQ);
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.be    = be_q;
    assign bus.wdata = wdata_q;

endmodule
